muldiv32: RTL and testbench
===========================

# muldiv32

Iterative 32-bit multiply/divide unit: the HI/LO responder that the single-cycle execute stage hands MULT/MULTU/DIV/DIVU operations to. It accepts one operation per request and computes it over 33 cycles with a shared shift/add–subtract datapath. It holds the architectural HI and LO registers and serves MFHI/MFLO reads and MTHI/MTLO writes. The execute stage stalls on `busy`.

## Interface
- `WIDTH`, 32: operand width; only 32 is supported.
- `clock` input 1: rising-edge clock.
- `reset_n` input 1: asynchronous, active-low reset.
- `start` input 1: request strobe, sampled only in IDLE.
- `op` input 2: operation code; 00 MULT, 01 MULTU, 10 DIV, 11 DIVU.
- `Read_data_1` input 32: rs operand; the dividend or multiplicand.
- `Read_data_2` input 32: rt operand; the divisor or multiplier.
- `hi_we` input 1: MTHI write enable.
- `lo_we` input 1: MTLO write enable.
- `wdata` input 32: MTHI/MTLO write data.
- `busy` output 1: high while an operation is in progress.
- `done` output 1: one-cycle pulse when HI/LO are updated.
- `div0` output 1: sticky flag set by a divide with divisor 0; cleared by the next `start`.
- `Hi` output 32: HI register.
- `Lo` output 32: LO register.

## Operation
- States:
  - IDLE → CALC when `start`=1.
  - CALC → FIX after 32 iterations.
  - FIX → IDLE unconditionally.
- Start edge, taken in IDLE with `start`=1:
  - Latch `op`.
  - Latch the operand magnitudes. Signed ops use absolute values; unsigned ops use raw values.
  - Record the result sign: MULT sign is sa^sb; DIV quotient sign is sa^sb and remainder sign is sa.
  - Set count=0 and clear `div0`.
- Multiply iterations (CALC): shift-add over a 64-bit accumulator, LSB-first on the multiplier; 32 iterations.
- Divide iterations (CALC): restoring division, MSB-first, with a 33-bit partial remainder; one quotient bit per iteration.
- FIX, multiply: negate the 64-bit product if its sign is set, then write {Hi,Lo}.
- FIX, divide: Lo=quotient and Hi=remainder, each sign-fixed.
- FIX, divide with divisor 0: Hi=original `Read_data_1`, Lo=32'hFFFF_FFFF, `div0`=1, no sign fix.
- DIV 0x8000_0000 / 0xFFFF_FFFF: Lo=0x8000_0000, Hi=0. No trap and no flag.
- `start` while busy: ignored. The requester must hold off until `busy`=0.
- `hi_we`/`lo_we` while busy: ignored.
- `hi_we`/`lo_we` in IDLE: the register is written at the edge.
- `start` and `hi_we`/`lo_we` in the same IDLE cycle: the write takes effect and is later overwritten by the result at FIX.
- Reset (any time, including mid-operation): the operation is aborted and the state returns to IDLE.
- Reset values: Hi=0, Lo=0, `busy`=0, `done`=0, `div0`=0, count=0.

## Timing
- Start sampled at edge T: `busy`=1 from T until edge T+33.
- Iterations run on edges T+1 through T+32.
- The FIX edge is T+33: Hi/Lo are updated there, `done`=1 for the following cycle, and `busy`=0 in that same cycle.
- Latency is 33 cycles. A new `start` can be accepted on edge T+34, which is the cycle `done` is high.
- `Hi`/`Lo` are registered outputs and keep their old values throughout CALC.

## Configuration
- `MULDIV_DIV_EN` defined: full behaviour as specified above.
- `MULDIV_DIV_EN` undefined:
  - The divide datapath is removed.
  - DIV/DIVU go IDLE → FIX in one cycle (`busy` high for one cycle, then `done`).
  - Hi/Lo are left unchanged and `div0` is set to 1 to flag the unsupported op.
  - Multiply is unaffected.

## Structure
- Package `muldiv_pkg` holds:
  - op encodings: OP_MULT, OP_MULTU, OP_DIV, OP_DIVU;
  - state enum: IDLE, CALC, FIX;
  - ITER=32 and the count width.
- One sub-module, `muldiv_iter`: a combinational single-iteration step. It takes the mode, accumulator/remainder and operand, and returns the next accumulator/remainder and quotient bit.
- The top level contains the FSM, the operand and sign registers, and the HI/LO registers.

## Test plan
- MULT 7 × 0xFFFF_FFFD (−3) → `done` 33 cycles after start; Hi=0xFFFF_FFFF, Lo=0xFFFF_FFEB.
- MULTU 0xFFFF_FFFF × 0xFFFF_FFFF → Hi=0xFFFF_FFFE, Lo=0x0000_0001.
- DIV 0xFFFF_FFF9 (−7) / 2 → Lo=0xFFFF_FFFD, Hi=0xFFFF_FFFF.
- DIV 0x8000_0000 / 0xFFFF_FFFF → Lo=0x8000_0000, Hi=0.
- DIVU 100 / 0 → `div0`=1, Hi=100, Lo=0xFFFF_FFFF. The next start clears `div0`.
- Busy and reset handling:
  - `start` and `hi_we` pulsed at cycle 10 of a MULT → both ignored and the result is unaffected.
  - `reset_n`=0 at cycle 20 → `busy`=0, Hi=Lo=0 immediately, and no `done` pulse.

Source files
------------

// File: rtl/muldiv_pkg.sv
// muldiv_pkg: op encodings, FSM states and iteration constants for muldiv32.
// Latency: none; this file holds declarations only.
// Backpressure: none.
package muldiv_pkg;

   localparam logic [1:0] OP_MULT  = 2'b00;
   localparam logic [1:0] OP_MULTU = 2'b01;
   localparam logic [1:0] OP_DIV   = 2'b10;
   localparam logic [1:0] OP_DIVU  = 2'b11;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CALC = 2'd1,
      FIX  = 2'd2
   } state_t;

   localparam int ITER  = 32;
   localparam int CNT_W = $clog2(ITER);

   function automatic logic op_is_div(input logic [1:0] o);
      return (o == OP_DIV) || (o == OP_DIVU);
   endfunction

   function automatic logic op_is_signed(input logic [1:0] o);
      return (o == OP_MULT) || (o == OP_DIV);
   endfunction

endpackage

// File: rtl/muldiv_iter.sv
// muldiv_iter: one combinational step of the shared shift/add - subtract datapath.
// Latency: combinational, zero cycles.
// Backpressure: none; the parent decides when a step is committed.
//
// Ports:
//   is_div   - 1 selects a restoring-divide step, 0 a shift-add multiply step
//   acc      - 2W-bit accumulator (multiply: {partial product, multiplier};
//              divide: low half holds the dividend shifting out MSB-first)
//   rem      - W-bit partial remainder (divide only)
//   operand  - multiplicand magnitude (multiply) or divisor magnitude (divide)
//   acc_nxt  - next accumulator; in divide mode its LSB is left 0 for q_bit
//   rem_nxt  - next partial remainder
//   q_bit    - quotient bit produced by this divide step (0 in multiply mode)
//
// Build option: MULDIV_DIV_EN defined keeps the divide path; undefined removes it.
module muldiv_iter #(
   parameter int W = 32
) (
   input  logic           is_div,
   input  logic [2*W-1:0] acc,
   input  logic [W-1:0]   rem,
   input  logic [W-1:0]   operand,
   output logic [2*W-1:0] acc_nxt,
   output logic [W-1:0]   rem_nxt,
   output logic           q_bit
);

   // W+1 bits so the carry out of the upper half shifts back into the accumulator.
   logic [W:0] mul_sum;
   assign mul_sum = {1'b0, acc[2*W-1:W]} + {1'b0, operand & {W{acc[0]}}};

`ifdef MULDIV_DIV_EN
   // The remainder stays below the divisor, so W bits hold it; only the
   // shifted trial value needs the extra bit for the compare.
   logic [W:0]   shifted;
   logic [W-1:0] diff;
   logic         ge;

   assign shifted = {rem, acc[W-1]};
   assign ge      = shifted >= {1'b0, operand};
   // Only used when ge, where the true difference fits in W bits.
   assign diff    = shifted[W-1:0] - operand;

   always_comb begin
      acc_nxt = {mul_sum, acc[W-1:1]};
      rem_nxt = rem;
      q_bit   = 1'b0;
      if (is_div) begin
         acc_nxt = {acc[2*W-1:W], acc[W-2:0], 1'b0};
         rem_nxt = ge ? diff : shifted[W-1:0];
         q_bit   = ge;
      end
   end
`else
   always_comb begin
      acc_nxt = is_div ? acc : {mul_sum, acc[W-1:1]};
      rem_nxt = rem;
      q_bit   = 1'b0;
   end
`endif

endmodule

// File: rtl/muldiv32.sv
// muldiv32: iterative MULT/MULTU/DIV/DIVU unit holding the HI/LO registers.
// Latency: 33 cycles from the start edge to HI/LO update; done pulses the cycle after.
// Backpressure: busy high while computing; start and MTHI/MTLO writes are dropped while busy.
//
// Ports:
//   clock, reset_n          - rising-edge clock, asynchronous active-low reset
//   start, op               - request strobe (sampled in IDLE) and op code
//   Read_data_1/Read_data_2 - rs (multiplicand/dividend), rt (multiplier/divisor)
//   hi_we, lo_we, wdata     - MTHI/MTLO writes, honoured only in IDLE
//   busy, done, div0        - status: in progress, result pulse, sticky divide-by-zero
//   Hi, Lo                  - architectural HI/LO registers
//
// Build option: MULDIV_DIV_EN enables division. Without it DIV/DIVU finish in
// one cycle, leave HI/LO untouched and raise div0 as an unsupported-op flag.
module muldiv32
   import muldiv_pkg::*;
#(
   parameter int WIDTH = 32
) (
   input  logic             clock,
   input  logic             reset_n,
   input  logic             start,
   input  logic [1:0]       op,
   input  logic [WIDTH-1:0] Read_data_1,
   input  logic [WIDTH-1:0] Read_data_2,
   input  logic             hi_we,
   input  logic             lo_we,
   input  logic [WIDTH-1:0] wdata,
   output logic             busy,
   output logic             done,
   output logic             div0,
   output logic [WIDTH-1:0] Hi,
   output logic [WIDTH-1:0] Lo
);

   state_t             state, state_nxt;
   logic [1:0]         op_q;
   logic [CNT_W-1:0]   count;
   logic [2*WIDTH-1:0] acc;
   logic [WIDTH-1:0]   rem;
   logic [WIDTH-1:0]   opnd;
   logic               neg_q;      // product / quotient sign
`ifdef MULDIV_DIV_EN
   logic               neg_r;      // remainder sign (sign of the dividend)
   logic               b_zero;     // divisor was zero at start
`endif

   // Operand magnitudes at the start edge.
   logic             sa, sb;
   logic [WIDTH-1:0] mag_a, mag_b;
   assign sa    = op_is_signed(op) & Read_data_1[WIDTH-1];
   assign sb    = op_is_signed(op) & Read_data_2[WIDTH-1];
   assign mag_a = sa ? -Read_data_1 : Read_data_1;
   assign mag_b = sb ? -Read_data_2 : Read_data_2;

   logic [2*WIDTH-1:0] it_acc;
   logic [WIDTH-1:0]   it_rem;
   logic               it_q;

   muldiv_iter #(.W(WIDTH)) u_iter (
      .is_div  (op_is_div(op_q)),
      .acc     (acc),
      .rem     (rem),
      .operand (opnd),
      .acc_nxt (it_acc),
      .rem_nxt (it_rem),
      .q_bit   (it_q)
   );

   // Sign-fixed results presented at FIX.
   logic [2*WIDTH-1:0] prod_fix;
   assign prod_fix = neg_q ? -acc : acc;
`ifdef MULDIV_DIV_EN
   logic [WIDTH-1:0] quot_fix, rem_fix;
   assign quot_fix = neg_q ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
   // With a zero divisor every trial subtract succeeds, so the remainder ends
   // as |rs| and the sign fix turns it back into the original rs.
   assign rem_fix  = neg_r ? -rem : rem;
`endif

   assign busy = (state != IDLE);

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) state <= IDLE;
      else          state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE: begin
            if (start) begin
`ifdef MULDIV_DIV_EN
               state_nxt = CALC;
`else
               state_nxt = op_is_div(op) ? FIX : CALC;
`endif
            end
         end
         CALC:    if (count == CNT_W'(ITER - 1)) state_nxt = FIX;
         FIX:     state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         op_q   <= OP_MULT;
         count  <= '0;
         acc    <= '0;
         rem    <= '0;
         opnd   <= '0;
         neg_q  <= 1'b0;
`ifdef MULDIV_DIV_EN
         neg_r  <= 1'b0;
         b_zero <= 1'b0;
`endif
         done   <= 1'b0;
         div0   <= 1'b0;
         Hi     <= '0;
         Lo     <= '0;
      end else begin
         done <= 1'b0;
         case (state)
            IDLE: begin
               if (hi_we) Hi <= wdata;
               if (lo_we) Lo <= wdata;
               if (start) begin
                  op_q  <= op;
                  count <= '0;
                  rem   <= '0;
                  div0  <= 1'b0;
                  neg_q <= sa ^ sb;
                  if (op_is_div(op)) begin
                     acc  <= {{WIDTH{1'b0}}, mag_a};
                     opnd <= mag_b;
                  end else begin
                     acc  <= {{WIDTH{1'b0}}, mag_b};
                     opnd <= mag_a;
                  end
`ifdef MULDIV_DIV_EN
                  neg_r  <= sa;
                  b_zero <= (Read_data_2 == '0);
`endif
               end
            end
            CALC: begin
               // In divide mode it_acc[0] is 0 and the quotient bit lands there;
               // in multiply mode it_q is 0.
               acc   <= {it_acc[2*WIDTH-1:1], it_acc[0] | it_q};
               rem   <= it_rem;
               count <= count + 1'b1;
            end
            FIX: begin
               done <= 1'b1;
               if (op_is_div(op_q)) begin
`ifdef MULDIV_DIV_EN
                  Hi   <= rem_fix;
                  Lo   <= b_zero ? {WIDTH{1'b1}} : quot_fix;
                  div0 <= b_zero;
`else
                  div0 <= 1'b1;
`endif
               end else begin
                  {Hi, Lo} <= prod_fix;
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_muldiv32.sv
module tb_muldiv32;

   logic        clock = 1'b0;
   logic        reset_n;
   logic        start;
   logic [1:0]  op;
   logic [31:0] Read_data_1, Read_data_2;
   logic        hi_we, lo_we;
   logic [31:0] wdata;
   logic        busy, done, div0;
   logic [31:0] Hi, Lo;

   int n_checks = 0;
   int n_fail   = 0;
   logic [31:0] exp_hi = 32'h0;
   logic [31:0] exp_lo = 32'h0;

   localparam logic [1:0] MULT = 2'b00, MULTU = 2'b01, DIV = 2'b10, DIVU = 2'b11;

   always #5 clock = ~clock;

   muldiv32 #(.WIDTH(32)) dut (
      .clock       (clock),
      .reset_n     (reset_n),
      .start       (start),
      .op          (op),
      .Read_data_1 (Read_data_1),
      .Read_data_2 (Read_data_2),
      .hi_we       (hi_we),
      .lo_we       (lo_we),
      .wdata       (wdata),
      .busy        (busy),
      .done        (done),
      .div0        (div0),
      .Hi          (Hi),
      .Lo          (Lo)
   );

   // Called at a falling edge; returns at the falling edge after the start edge.
   task automatic issue(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
      op = o; Read_data_1 = a; Read_data_2 = b; start = 1'b1;
      @(negedge clock);
      start = 1'b0;
   endtask

   // Counts falling edges until done is seen; gives up after 100.
   task automatic wait_done(output int cycles);
      cycles = 0;
      while (done !== 1'b1 && cycles < 100) begin
         @(negedge clock);
         cycles++;
      end
   endtask

   task automatic test_reset;
      reset_n = 1'b0; start = 1'b0; op = MULT; Read_data_1 = '0; Read_data_2 = '0;
      hi_we = 1'b0; lo_we = 1'b0; wdata = '0;
      repeat (2) @(negedge clock);
      n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got %b want 0", busy); end
      n_checks++; if (done !== 1'b0) begin n_fail++; $display("FAIL reset_done got %b want 0", done); end
      n_checks++; if (div0 !== 1'b0) begin n_fail++; $display("FAIL reset_div0 got %b want 0", div0); end
      n_checks++; if (Hi !== 32'h0) begin n_fail++; $display("FAIL reset_hi got %h want 0", Hi); end
      n_checks++; if (Lo !== 32'h0) begin n_fail++; $display("FAIL reset_lo got %h want 0", Lo); end
      reset_n = 1'b1;
      @(negedge clock);
   endtask

   task automatic test_mult;
      int cyc;
      issue(MULT, 32'h0000_0007, 32'hFFFF_FFFD);
      n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL mult_busy got %b want 1", busy); end
      wait_done(cyc);
      n_checks++; if (cyc != 33) begin n_fail++; $display("FAIL mult_latency got %0d want 33", cyc); end
      n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL mult_busy_at_done got %b want 0", busy); end
      n_checks++; if (Hi !== 32'hFFFF_FFFF) begin n_fail++; $display("FAIL mult_hi got %h want ffffffff", Hi); end
      n_checks++; if (Lo !== 32'hFFFF_FFEB) begin n_fail++; $display("FAIL mult_lo got %h want ffffffeb", Lo); end
      @(negedge clock);
      n_checks++; if (done !== 1'b0) begin n_fail++; $display("FAIL mult_done_pulse got %b want 0", done); end
   endtask

   task automatic test_multu;
      int cyc;
      issue(MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
      wait_done(cyc);
      n_checks++; if (cyc != 33) begin n_fail++; $display("FAIL multu_latency got %0d want 33", cyc); end
      n_checks++; if (Hi !== 32'hFFFF_FFFE) begin n_fail++; $display("FAIL multu_hi got %h want fffffffe", Hi); end
      n_checks++; if (Lo !== 32'h0000_0001) begin n_fail++; $display("FAIL multu_lo got %h want 00000001", Lo); end
      exp_hi = 32'hFFFF_FFFE; exp_lo = 32'h0000_0001;
      @(negedge clock);
   endtask

   task automatic test_div;
      logic [1:0]  t_op [6] = '{DIV, DIV, DIV, DIVU, DIV, DIVU};
      logic [31:0] t_a  [6] = '{32'hFFFF_FFF9, 32'h8000_0000, 32'd100, 32'hFFFF_FFFF, 32'hFFFF_FFF9, 32'd100};
      logic [31:0] t_b  [6] = '{32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFF9, 32'h10, 32'h0, 32'h0};
      logic [31:0] t_hi [6] = '{32'hFFFF_FFFF, 32'h0, 32'd2, 32'hF, 32'hFFFF_FFF9, 32'd100};
      logic [31:0] t_lo [6] = '{32'hFFFF_FFFD, 32'h8000_0000, 32'hFFFF_FFF2, 32'h0FFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
      logic        t_d0 [6] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
      int cyc;
      for (int i = 0; i < 6; i++) begin
         issue(t_op[i], t_a[i], t_b[i]);
         n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL div%0d_busy got %b want 1", i, busy); end
         wait_done(cyc);
`ifdef MULDIV_DIV_EN
         n_checks++; if (cyc != 33) begin n_fail++; $display("FAIL div%0d_latency got %0d want 33", i, cyc); end
         exp_hi = t_hi[i]; exp_lo = t_lo[i];
         n_checks++; if (div0 !== t_d0[i]) begin n_fail++; $display("FAIL div%0d_div0 got %b want %b", i, div0, t_d0[i]); end
`else
         n_checks++; if (cyc != 1) begin n_fail++; $display("FAIL div%0d_latency got %0d want 1", i, cyc); end
         n_checks++; if (div0 !== 1'b1) begin n_fail++; $display("FAIL div%0d_div0 got %b want 1 (t_d0 %b)", i, div0, t_d0[i]); end
`endif
         n_checks++; if (Hi !== exp_hi) begin n_fail++; $display("FAIL div%0d_hi got %h want %h", i, Hi, exp_hi); end
         n_checks++; if (Lo !== exp_lo) begin n_fail++; $display("FAIL div%0d_lo got %h want %h", i, Lo, exp_lo); end
         @(negedge clock);
      end
   endtask

   task automatic test_div0_clear;
      int cyc;
      n_checks++; if (div0 !== 1'b1) begin n_fail++; $display("FAIL div0_sticky got %b want 1", div0); end
      issue(MULT, 32'd2, 32'd3);
      n_checks++; if (div0 !== 1'b0) begin n_fail++; $display("FAIL div0_clear got %b want 0", div0); end
      wait_done(cyc);
      n_checks++; if (Lo !== 32'd6) begin n_fail++; $display("FAIL div0_next_lo got %h want 6", Lo); end
      exp_hi = 32'h0; exp_lo = 32'd6;
      @(negedge clock);
   endtask

   task automatic test_mthi_mtlo;
      int cyc;
      hi_we = 1'b1; wdata = 32'hA5A5_0001;
      @(negedge clock);
      hi_we = 1'b0;
      n_checks++; if (Hi !== 32'hA5A5_0001) begin n_fail++; $display("FAIL mthi got %h want a5a50001", Hi); end
      n_checks++; if (Lo !== exp_lo) begin n_fail++; $display("FAIL mthi_lo_kept got %h want %h", Lo, exp_lo); end
      lo_we = 1'b1; wdata = 32'h5A5A_0002;
      @(negedge clock);
      lo_we = 1'b0;
      n_checks++; if (Lo !== 32'h5A5A_0002) begin n_fail++; $display("FAIL mtlo got %h want 5a5a0002", Lo); end
      hi_we = 1'b1; wdata = 32'h1111_2222;
      issue(MULT, 32'd3, 32'd5);
      hi_we = 1'b0;
      n_checks++; if (Hi !== 32'h1111_2222) begin n_fail++; $display("FAIL mthi_with_start got %h want 11112222", Hi); end
      wait_done(cyc);
      n_checks++; if (Hi !== 32'h0) begin n_fail++; $display("FAIL mthi_overwritten_hi got %h want 0", Hi); end
      n_checks++; if (Lo !== 32'd15) begin n_fail++; $display("FAIL mthi_overwritten_lo got %h want f", Lo); end
      exp_hi = 32'h0; exp_lo = 32'd15;
      @(negedge clock);
   endtask

   task automatic test_busy_ignore;
      int cyc;
      issue(MULT, 32'hFFFF_0000, 32'h0000_0100);
      repeat (9) @(negedge clock);
      op = DIVU; Read_data_1 = 32'h1234_5678; Read_data_2 = 32'h3;
      start = 1'b1; hi_we = 1'b1; lo_we = 1'b1; wdata = 32'hDEAD_BEEF;
      @(negedge clock);
      start = 1'b0; hi_we = 1'b0; lo_we = 1'b0;
      n_checks++; if (Hi !== exp_hi) begin n_fail++; $display("FAIL busy_hi_held got %h want %h", Hi, exp_hi); end
      n_checks++; if (Lo !== exp_lo) begin n_fail++; $display("FAIL busy_lo_held got %h want %h", Lo, exp_lo); end
      wait_done(cyc);
      n_checks++; if (cyc + 10 != 33) begin n_fail++; $display("FAIL busy_latency got %0d want 33", cyc + 10); end
      n_checks++; if (Hi !== 32'hFFFF_FFFF) begin n_fail++; $display("FAIL busy_hi got %h want ffffffff", Hi); end
      n_checks++; if (Lo !== 32'hFF00_0000) begin n_fail++; $display("FAIL busy_lo got %h want ff000000", Lo); end
      @(negedge clock);
      n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL busy_no_restart got %b want 0", busy); end
      exp_hi = 32'hFFFF_FFFF; exp_lo = 32'hFF00_0000;
   endtask

   task automatic test_back_to_back;
      int cyc;
      issue(MULTU, 32'h0001_0000, 32'h0001_0000);
      wait_done(cyc);
      n_checks++; if (Hi !== 32'h1 || Lo !== 32'h0) begin n_fail++; $display("FAIL b2b_first got %h_%h want 00000001_00000000", Hi, Lo); end
      // Issue in the done cycle: sampled on edge T+34.
      issue(MULT, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
      n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL b2b_accept got %b want 1", busy); end
      wait_done(cyc);
      n_checks++; if (cyc != 33) begin n_fail++; $display("FAIL b2b_latency got %0d want 33", cyc); end
      n_checks++; if (Hi !== 32'h0 || Lo !== 32'h1) begin n_fail++; $display("FAIL b2b_second got %h_%h want 00000000_00000001", Hi, Lo); end
      @(negedge clock);
   endtask

   task automatic test_reset_mid;
      int pulses;
      issue(MULT, 32'd5, 32'd5);
      repeat (19) @(negedge clock);
      reset_n = 1'b0;
      #1;
      n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL rstmid_busy got %b want 0", busy); end
      n_checks++; if (Hi !== 32'h0) begin n_fail++; $display("FAIL rstmid_hi got %h want 0", Hi); end
      n_checks++; if (Lo !== 32'h0) begin n_fail++; $display("FAIL rstmid_lo got %h want 0", Lo); end
      @(negedge clock);
      reset_n = 1'b1;
      pulses = 0;
      for (int i = 0; i < 40; i++) begin
         @(negedge clock);
         if (done === 1'b1) pulses++;
      end
      n_checks++; if (pulses != 0) begin n_fail++; $display("FAIL rstmid_done_pulses got %0d want 0", pulses); end
      n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL rstmid_idle got %b want 0", busy); end
   endtask

   initial begin
      test_reset;
      test_mult;
      test_multu;
      test_div;
      test_div0_clear;
      test_mthi_mtlo;
      test_busy_ignore;
      test_back_to_back;
      test_reset_mid;
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
